fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage of the pipelined RV32I core, sitting directly upstream of the decode/control stage. Holds the PC, issues in-order word requests to instruction memory over a valid/ready handshake, buffers returned instructions with their PCs in a small FIFO, and presents one instruction per cycle to decode. On a taken branch/jump redirect from execute it flushes buffered and in-flight fetches and restarts at the target.

## Interface
- RESET_PC, 32'h0000_0000, PC fetched first after reset
- DEPTH, 4, instruction FIFO entries; also maximum outstanding plus buffered fetches (power of two, ≥2)
- i_clk  in  1  clock, rising edge
- i_reset  in  1  reset, asynchronous, active-high
- o_imem_req_vld  out  1  fetch request valid
- o_imem_addr  out  32  fetch word address (bits [1:0] always 0)
- i_imem_req_rdy  in  1  memory accepts request
- i_imem_rsp_vld  in  1  response valid (in order, ≥1 cycle after acceptance, no backpressure)
- i_imem_rsp_data  in  32  instruction word
- i_redirect  in  1  taken branch/jal/jalr from execute (the PC-select result)
- i_redirect_pc  in  32  redirect target
- i_stall  in  1  decode cannot accept this cycle
- o_inst_vld  out  1  o_inst/o_pc valid
- o_inst  out  32  instruction to decode (NOP 32'h0000_0013 when invalid)
- o_pc  out  32  PC of o_inst
- o_pc_four  out  32  o_pc + 4
- o_misalign  out  1  one-cycle pulse: redirect target had bits [1:0] ≠ 0

## Operation
- Request: o_imem_req_vld = ~i_redirect & (outstanding + count − pop < DEPTH); o_imem_addr = pc. Handshake (vld & rdy): pc <= pc + 4 (wraps modulo 2^32), outstanding increments.
- Response: if drop_cnt > 0, discard and decrement drop_cnt; else push {pc_of_request, data} to FIFO. A per-request PC queue (same DEPTH) tracks request addresses; entries pop in order with responses.
- Output: o_inst_vld = FIFO not empty; pop when o_inst_vld & ~i_stall. Empty → o_inst = NOP, o_pc/o_pc_four hold last value.
- Redirect (highest priority): pc <= {i_redirect_pc[31:2], 2'b00}; FIFO and PC queue cleared; no request issued this cycle; drop_cnt <= outstanding after this cycle's response accounting; outstanding unchanged (drained by dropped responses). Same-cycle pop is ignored. o_misalign <= |i_redirect_pc[1:0].
- Response in redirect cycle: counted as discarded (not in new drop_cnt).
- Redirect while drop_cnt > 0: drop_cnt recomputed from total outstanding; no double count.
- Counters never exceed DEPTH; overflow of FIFO is impossible by credit rule (assertion).

## Timing
- Reset values: pc = RESET_PC, outstanding = 0, drop_cnt = 0, FIFO empty; o_imem_req_vld = 0 while i_reset high, o_inst_vld = 0, o_inst = NOP, o_pc = RESET_PC, o_pc_four = RESET_PC + 4, o_misalign = 0.
- First request cycle after reset deasserts; address RESET_PC.
- Response-to-output latency: 1 cycle (registered FIFO write, combinational head read).
- Redirect-to-new-request: 1 cycle (request at target in cycle after i_redirect).
- Throughput: 1 instruction/cycle with 1-cycle memory, DEPTH ≥ 2, no stall.
- Reset mid-operation: all state cleared immediately; late responses after reset are not accepted (memory also reset).

## Structure
- Shared package rv_pkg: NOP_INST = 32'h0000_0013, XLEN = 32, fetch-entry struct {pc, inst}.
- Sub-module fetch_fifo: synchronous FIFO, parameter DEPTH/WIDTH, push/pop/clear, count, async active-high reset; instantiated twice (instruction FIFO width 64, PC queue width 32).

## Test plan
- Reset, RESET_PC = 32'h100, always-ready 1-cycle memory → requests 0x100, 0x104, 0x108…; o_inst_vld from cycle 2, one instruction per cycle, o_pc_four = o_pc + 4.
- i_stall high 6 cycles → FIFO fills to DEPTH, o_imem_req_vld drops, no instruction lost or duplicated on release.
- Memory latency 3, 2 in flight, redirect to 0x200 → both late responses dropped, next o_inst_vld shows o_pc = 0x200.
- Redirect to 0x203 → fetch at 0x200, o_misalign pulses one cycle.
- i_imem_req_rdy toggling randomly → o_imem_addr stable while vld & ~rdy, address sequence contiguous.
- Back-to-back redirects (0x300 then 0x400) with responses pending → only 0x400 stream reaches decode.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV32I core definitions used by the fetch stage and its buffers.
package rv_pkg;
  localparam int          XLEN     = 32;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; head is read combinationally, writes land on the next edge.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  // Storage carries no reset; validity is tracked entirely by count.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (!(push && full && !pop));
  end
endmodule

// File: rtl/fetch_unit.sv
// RV32I fetch stage: PC, in-order imem requests, instruction buffer, redirect flush.
module fetch_unit
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  output logic        o_imem_req_vld,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_req_rdy,
  input  logic        i_imem_rsp_vld,
  input  logic [31:0] i_imem_rsp_data,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  input  logic        i_stall,
  output logic        o_inst_vld,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_four,
  output logic        o_misalign
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   pc, last_pc, pcq_head;
  logic [CW-1:0] outstanding, drop_cnt, fifo_count, pcq_count;
  logic [CW:0]   used;
  logic          fifo_empty, fifo_full, pcq_empty, pcq_full;
  logic          pop, hs, rsp_keep;
  fetch_entry_t  head, push_entry;

  // Same-cycle pop is dropped on redirect since the whole buffer is flushed anyway.
  assign pop  = ~fifo_empty & ~i_stall & ~i_redirect;
  assign used = {1'b0, outstanding} + {1'b0, fifo_count} - {{CW{1'b0}}, pop};

  // Credit rule: every in-flight request owns a FIFO slot, so responses never overflow.
  assign o_imem_req_vld = ~i_reset & ~i_redirect & (used < (CW+1)'(DEPTH));
  assign o_imem_addr    = pc;
  assign hs             = o_imem_req_vld & i_imem_req_rdy;

  assign rsp_keep   = i_imem_rsp_vld & (drop_cnt == '0) & ~i_redirect;
  assign push_entry = '{pc: pcq_head, inst: i_imem_rsp_data};

  fetch_fifo #(.DEPTH(DEPTH), .WIDTH($bits(fetch_entry_t))) u_inst_fifo (
    .clk   (i_clk),
    .rst   (i_reset),
    .clear (i_redirect),
    .push  (rsp_keep),
    .pop   (pop),
    .wdata (push_entry),
    .rdata (head),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  fetch_fifo #(.DEPTH(DEPTH), .WIDTH(XLEN)) u_pc_queue (
    .clk   (i_clk),
    .rst   (i_reset),
    .clear (i_redirect),
    .push  (hs),
    .pop   (rsp_keep),
    .wdata (pc),
    .rdata (pcq_head),
    .count (pcq_count),
    .empty (pcq_empty),
    .full  (pcq_full)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      last_pc     <= RESET_PC;
      o_misalign  <= 1'b0;
    end else begin
      outstanding <= outstanding + {{(CW-1){1'b0}}, hs} - {{(CW-1){1'b0}}, i_imem_rsp_vld};
      o_misalign  <= i_redirect & (|i_redirect_pc[1:0]);
      if (!fifo_empty) last_pc <= head.pc;
      if (i_redirect) begin
        pc <= {i_redirect_pc[31:2], 2'b00};
        // Everything still in flight after this cycle's response belongs to the old stream.
        drop_cnt <= outstanding - {{(CW-1){1'b0}}, i_imem_rsp_vld};
      end else begin
        if (hs) pc <= pc + 32'd4;
        if (i_imem_rsp_vld && drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
      end
    end
  end

  assign o_inst_vld = ~fifo_empty;
  assign o_inst     = fifo_empty ? NOP_INST : head.inst;
  assign o_pc       = fifo_empty ? last_pc : head.pc;
  assign o_pc_four  = o_pc + 32'd4;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      assert (!(rsp_keep && fifo_full && !pop));
      assert (!(rsp_keep && pcq_empty));
      assert (!(hs && pcq_full));
      assert (pcq_count <= outstanding);
      assert (outstanding <= CW'(DEPTH) && drop_cnt <= outstanding);
    end
  end
endmodule
